// File: rtl/instr_encoder.sv
// Purpose: packs ALU instruction fields into 32-bit decoder words and buffers them in a DEPTH-entry FIFO.
// Latency: a word pushed into an empty FIFO is on OUT with out_valid=1 right after the push edge.
// Backpressure: in_ready drops when full (a same-cycle pop does not relax it); OUT holds while out_ready=0.
// Build option: define SHAMT_CLAMP_EN to clamp SLA/SRA shift amounts above 31 to 31.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [1:0]                 in_rs,
  input  logic [1:0]                 in_rt,
  input  logic [7:0]                 in_shamt,
  input  logic [1:0]                 in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                OUT,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CW-1:0]              issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SLA = 2'd2;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] issued_cnt_q, issued_cnt_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic [31:0] enc_word;
  logic [7:0]  opcode;
  logic [7:0]  shamt_enc;
  logic [7:0]  mid_field;
  logic        push;
  logic        pop;

  assign in_ready   = (level_q != FULL_LVL);
  assign out_valid  = (level_q != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign level      = level_q;
  assign issued_cnt = issued_cnt_q;
  // Head entry comes straight from storage, so there is no path from in_* to OUT.
  assign OUT        = out_valid ? mem_q[rd_ptr_q] : 32'h0;

  // Encode the incoming field set into the decoder word format.
  always_comb begin
    opcode    = 8'h00;
    shamt_enc = in_shamt;
    mid_field = 8'h00;
    case (in_op)
      OP_ADD:  opcode = 8'h20;
      OP_SUB:  opcode = 8'h10;
      OP_SLA:  opcode = 8'h08;
      default: opcode = 8'h04;
    endcase
`ifdef SHAMT_CLAMP_EN
    // Shifting a 32-bit datapath by more than 31 is meaningless; saturate.
    if (in_shamt > 8'd31) begin
      shamt_enc = 8'd31;
    end
`else
    shamt_enc = in_shamt;
`endif
    if (in_op == OP_ADD || in_op == OP_SUB) begin
      mid_field = {6'b0, in_rt};
    end else begin
      mid_field = shamt_enc;
    end
    enc_word = {opcode, 6'b0, in_rs, mid_field, 6'b0, in_rd};
  end

  // Next-state for pointers, occupancy, pop counter and storage; flush wins over push/pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    issued_cnt_d = issued_cnt_q;
    mem_d        = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = enc_word;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        issued_cnt_d = issued_cnt_q + 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // Control state, cleared asynchronously by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      issued_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // Word storage; contents are don't-care after reset since level gates visibility.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: scoreboard bench for instr_encoder; stimulus queues expected words, a monitor checks each pop.
// Latency: checks status one step after each rising edge, pops are checked on the falling edge before the pop.
// Backpressure: out_ready is driven by the stimulus to exercise hold, full and drain cases.
module tb_instr_encoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [1:0]  in_rs;
  logic [1:0]  in_rt;
  logic [7:0]  in_shamt;
  logic [1:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] OUT;
  logic [2:0]  level;
  logic [15:0] issued_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  instr_encoder #(.DEPTH(4), .CW(16)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT),
    .level(level), .issued_cnt(issued_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge, so compare the head word now.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got 0x%08h expected no word", OUT);
      end else begin
        check("pop_word", OUT, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [7:0] sh, input logic [1:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_shamt = sh;
    in_rd    = rd;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rt,
                      input logic [7:0] sh, input logic [1:0] rd, input logic [31:0] exp);
    drive(op, rs, rt, sh, rd);
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // Hand-encoded vectors for the full/wrap test.
  logic [1:0]  v_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0]  v_rs [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0};
  logic [1:0]  v_rt [8] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
  logic [7:0]  v_sh [8] = '{8'h00, 8'h00, 8'h11, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h07};
  logic [1:0]  v_rd [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3};
  logic [31:0] v_ex [8] = '{32'h20000102, 32'h10010203, 32'h08021100, 32'h04031F01,
                            32'h20030303, 32'h10000000, 32'h08010002, 32'h04000703};

  initial begin
    logic [31:0] clamp_exp;
`ifdef SHAMT_CLAMP_EN
    clamp_exp = 32'h04021F00;
`else
    clamp_exp = 32'h0402C800;
`endif
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'd0; in_rs = 2'd0; in_rt = 2'd0; in_shamt = 8'd0; in_rd = 2'd0;
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out", OUT, 32'h0);
    check("rst_issued", 32'(issued_cnt), 32'd0);
    RST = 1'b0;
    tick();

    // Single ADD, held then popped.
    push(2'd0, 2'd1, 2'd2, 8'd0, 2'd3, 32'h20010203);
    check("add_out", OUT, 32'h20010203);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_level", 32'(level), 32'd1);
    tick();
    check("add_hold", OUT, 32'h20010203);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_level_after", 32'(level), 32'd0);
    check("add_issued", 32'(issued_cnt), 32'd1);
    check("add_out_empty", OUT, 32'h0);

    // Mixed ops; rt=3 on SLA must be ignored.
    push(2'd1, 2'd3, 2'd0, 8'd0, 2'd2, 32'h10030002);
    push(2'd2, 2'd0, 2'd3, 8'd5, 2'd1, 32'h08000501);
    check("mix_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("mix_issued", 32'(issued_cnt), 32'd3);
    check("mix_level_after", 32'(level), 32'd0);

    // Fill to DEPTH, hold a 5th, then pop-only, then push+pop, then drain across the wrap.
    for (int i = 0; i < 4; i++) push(v_op[i], v_rs[i], v_rt[i], v_sh[i], v_rd[i], v_ex[i]);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(v_op[4], v_rs[4], v_rt[4], v_sh[4], v_rd[4]);
    tick();
    check("full_hold_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    tick();
    check("full_pop_only_level", 32'(level), 32'd3);
    for (int i = 4; i < 8; i++) begin
      drive(v_op[i], v_rs[i], v_rt[i], v_sh[i], v_rd[i]);
      exp_q.push_back(v_ex[i]);
      tick();
      check("pushpop_level", 32'(level), 32'd3);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_issued", 32'(issued_cnt), 32'd11);

    // Shift amount above 31.
    push(2'd3, 2'd2, 2'd0, 8'd200, 2'd0, clamp_exp);
    check("clamp_out", OUT, clamp_exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("clamp_issued", 32'(issued_cnt), 32'd12);

    // Flush beats concurrent push and pop.
    for (int i = 0; i < 3; i++) push(v_op[i], v_rs[i], v_rt[i], v_sh[i], v_rd[i], v_ex[i]);
    check("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(2'd0, 2'd1, 2'd1, 8'd0, 2'd1);
    tick();
    exp_q.delete();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_out", OUT, 32'h0);
    check("flush_issued", 32'(issued_cnt), 32'd12);

    // Asynchronous reset between edges with entries in flight.
    push(v_op[4], v_rs[4], v_rt[4], v_sh[4], v_rd[4], v_ex[4]);
    push(v_op[5], v_rs[5], v_rt[5], v_sh[5], v_rd[5], v_ex[5]);
    check("arst_pre_level", 32'(level), 32'd2);
    #2;
    RST = 1'b1;
    exp_q.delete();
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_issued", 32'(issued_cnt), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out", OUT, 32'h0);
    tick();
    RST = 1'b0;
    tick();
    push(2'd0, 2'd2, 2'd1, 8'd0, 2'd1, 32'h20020101);
    check("post_rst_out", OUT, 32'h20020101);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_issued", 32'(issued_cnt), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
